// File: rtl/vram_snoop.sv
// CPU-bus snooper: video-window writes queue in a FIFO, drain one per cycle into a 2 KB shadow RAM.
// Event to RAM write is 2 cycles (no backlog); freeze holds the drain; a full FIFO drops and counts, never stalls.
module vram_snoop_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_dat,
  output logic          o_empty,
  output logic          o_pop_ok,
  output logic          o_push_ok,
  output logic [LW-1:0] o_level
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [LW-1:0] r_level;
  logic          w_full;

  assign o_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(DEPTH));
  assign o_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign o_push_ok = i_push && (!w_full || o_pop_ok);
  assign o_dat     = r_mem[r_rp];
  assign o_level   = r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (o_push_ok) r_wp <= r_wp + PW'(1);
      if (o_pop_ok)  r_rp <= r_rp + PW'(1);
      case ({o_push_ok, o_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_push_ok) r_mem[r_wp] <= i_dat;
  end
endmodule

module vram_snoop #(
  parameter logic [15:0] VRAM_BASE  = 16'h8000,
  parameter int          VRAM_SIZE  = 2048,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        fpga_clk,
  input  logic        fpga_reset,
  input  logic        cpu_phi2,
  input  logic        cpu_rwb,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic        snoop_enable,
  input  logic        freeze,
  input  logic [10:0] vram_address,
  output logic [7:0]  vram_data,
  output logic [3:0]  fifo_level,
  output logic        overflow,
  output logic [7:0]  drop_count,
  input  logic        clear_overflow
);
  localparam int          LW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [16:0] SIZE17 = 17'(VRAM_SIZE);

  logic        r_phi2_s1, r_phi2_s2, r_rwb_s1, r_rwb_s2;
  logic [15:0] r_addr_s1, r_addr_s2;
  logic [7:0]  r_data_s1, r_data_s2;
  logic [7:0]  r_shadow [VRAM_SIZE];
  logic [7:0]  r_vram_data;
  logic        r_overflow;
  logic [7:0]  r_drop_count;

  logic [15:0]   w_off;
  logic          w_event, w_push, w_push_ok, w_pop_ok, w_empty, w_drop;
  logic [18:0]   w_fifo_dat;
  logic [LW-1:0] w_level;

  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      r_phi2_s1 <= 1'b0;
      r_phi2_s2 <= 1'b0;
      r_rwb_s1  <= 1'b0;
      r_rwb_s2  <= 1'b0;
      r_addr_s1 <= '0;
      r_addr_s2 <= '0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
    end else begin
      r_phi2_s1 <= cpu_phi2;
      r_phi2_s2 <= r_phi2_s1;
      r_rwb_s1  <= cpu_rwb;
      r_rwb_s2  <= r_rwb_s1;
      r_addr_s1 <= cpu_address;
      r_addr_s2 <= r_addr_s1;
      r_data_s1 <= cpu_data;
      r_data_s2 <= r_data_s1;
    end
  end

  // Stage-2 bus values were sampled during the last phi2-high cycle.
  assign w_event = r_phi2_s2 && !r_phi2_s1;
  assign w_off   = r_addr_s2 - VRAM_BASE;
  assign w_push  = w_event && snoop_enable && !r_rwb_s2 && ({1'b0, w_off} < SIZE17);
  assign w_drop  = w_push && !w_push_ok;

  vram_snoop_fifo #(.W(19), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .i_clk     (fpga_clk),
    .i_rst_n   (fpga_reset),
    .i_push    (w_push),
    .i_dat     ({w_off[10:0], r_data_s2}),
    .i_pop     (!freeze),
    .o_dat     (w_fifo_dat),
    .o_empty   (w_empty),
    .o_pop_ok  (w_pop_ok),
    .o_push_ok (w_push_ok),
    .o_level   (w_level)
  );

  always_ff @(posedge fpga_clk) begin
    if (w_pop_ok) r_shadow[w_fifo_dat[18:8]] <= w_fifo_dat[7:0];
  end

  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) r_vram_data <= '0;
    else             r_vram_data <= r_shadow[vram_address];
  end

  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      if (clear_overflow)              r_drop_count <= 8'd1;
      else if (r_drop_count != 8'hFF)  r_drop_count <= r_drop_count + 8'd1;
    end else if (clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign vram_data  = r_vram_data;
  assign fifo_level = 4'(w_level);
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  // w_empty is implied by w_pop_ok; kept visible for debug probing.
  logic w_unused;
  assign w_unused = w_empty;
endmodule

// File: tb/tb_vram_snoop.sv
// Directed bench for vram_snoop with a queue-based reference model checked every cycle.
module tb_vram_snoop;
  localparam int DEPTH = 8;

  logic        fpga_clk = 1'b0;
  logic        fpga_reset = 1'b0;
  logic        cpu_phi2 = 1'b0;
  logic        cpu_rwb = 1'b1;
  logic [15:0] cpu_address = '0;
  logic [7:0]  cpu_data = '0;
  logic        snoop_enable = 1'b0;
  logic        freeze = 1'b0;
  logic        clear_overflow = 1'b0;
  logic [10:0] vram_address = '0;
  logic [7:0]  vram_data, drop_count;
  logic [3:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int peak = 0;

  always #5 fpga_clk = ~fpga_clk;

  vram_snoop dut (
    .fpga_clk(fpga_clk), .fpga_reset(fpga_reset), .cpu_phi2(cpu_phi2), .cpu_rwb(cpu_rwb),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .snoop_enable(snoop_enable), .freeze(freeze),
    .vram_address(vram_address), .vram_data(vram_data), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count), .clear_overflow(clear_overflow)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bus samples delayed two clocks, a queue for the FIFO, an array for the RAM.
  typedef struct { bit phi; bit rwb; bit [15:0] a; bit [7:0] d; } bus_t;
  typedef struct { bit [10:0] off; bit [7:0] d; } ent_t;
  bus_t h_new, h_old;
  ent_t q[$];
  bit [7:0] sh [2048];
  bit       kn [2048];
  int       m_level, m_dc;
  bit       m_ov, m_vd_kn;
  bit [7:0] m_vd;

  always @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      h_new = '{0, 0, 0, 0};
      h_old = '{0, 0, 0, 0};
      q.delete();
      m_level = 0; m_dc = 0; m_ov = 0; m_vd = 0; m_vd_kn = 1;
    end else begin
      bit evt, push, drop;
      bit [15:0] off;
      ent_t e;
      m_vd = sh[vram_address];
      m_vd_kn = kn[vram_address];
      evt = h_old.phi && !h_new.phi;
      off = h_old.a - 16'h8000;
      push = evt && snoop_enable && !h_old.rwb && (off < 16'd2048);
      if (!freeze && q.size() > 0) begin
        e = q.pop_front();
        sh[e.off] = e.d;
        kn[e.off] = 1;
      end
      drop = 0;
      if (push) begin
        if (q.size() < DEPTH) q.push_back('{off[10:0], h_old.d});
        else drop = 1;
      end
      if (drop) begin
        m_ov = 1;
        m_dc = clear_overflow ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
      end else if (clear_overflow) begin
        m_ov = 0;
        m_dc = 0;
      end
      m_level = q.size();
      h_old = h_new;
      h_new = '{cpu_phi2, cpu_rwb, cpu_address, cpu_data};
    end
  end

  always @(negedge fpga_clk) begin
    if (fpga_reset) begin
      check("mdl_level", 32'(fifo_level), 32'(m_level));
      check("mdl_overflow", 32'(overflow), 32'(m_ov));
      check("mdl_drop_count", 32'(drop_count), 32'(m_dc));
      if (m_vd_kn) check("mdl_vram_data", 32'(vram_data), 32'(m_vd));
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
  end

  // tweak: 1 = release freeze in the push cycle, 2 = pulse clear_overflow in the push cycle.
  task automatic cpu_cycle(input bit [15:0] a, input bit [7:0] d, input bit rwb, input int tweak);
    cpu_address = a; cpu_data = d; cpu_rwb = rwb; cpu_phi2 = 1'b1;
    repeat (4) @(negedge fpga_clk);
    cpu_phi2 = 1'b0;
    @(negedge fpga_clk);
    if (tweak == 1) freeze = 1'b0;
    if (tweak == 2) clear_overflow = 1'b1;
    @(negedge fpga_clk);
    clear_overflow = 1'b0;
    repeat (2) @(negedge fpga_clk);
    cpu_rwb = 1'b1;
  endtask

  task automatic read_chk(input string nm, input bit [10:0] addr, input bit [7:0] exp);
    vram_address = addr;
    @(negedge fpga_clk);
    check(nm, 32'(vram_data), 32'(exp));
  endtask

  initial begin
    int lat;
    bit found;
    repeat (3) @(negedge fpga_clk);
    check("rst_vram_data", 32'(vram_data), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    fpga_reset = 1'b1;
    snoop_enable = 1'b1;
    repeat (2) @(negedge fpga_clk);

    // First write and its latency from the phi2 fall.
    vram_address = 11'd0; peak = 0;
    cpu_address = 16'h8000; cpu_data = 8'h41; cpu_rwb = 1'b0; cpu_phi2 = 1'b1;
    repeat (4) @(negedge fpga_clk);
    cpu_phi2 = 1'b0; lat = 0; found = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(negedge fpga_clk);
      if (vram_data === 8'h41) begin found = 1; lat = i; end
    end
    cpu_rwb = 1'b1;
    check("t1_seen", 32'(found), 1);
    check("t1_latency", 32'(lat), 4);
    repeat (3) @(negedge fpga_clk);
    check("t1_peak", 32'(peak), 1);
    check("t1_level_idle", 32'(fifo_level), 0);

    cpu_cycle(16'h8001, 8'hA1, 1'b0, 0);
    cpu_cycle(16'h8005, 8'hA5, 1'b0, 0);
    cpu_cycle(16'h8018, 8'h5A, 1'b0, 0);

    // Ignored cycles.
    peak = 0;
    cpu_cycle(16'h7FFF, 8'h11, 1'b0, 0);
    cpu_cycle(16'h8800, 8'h22, 1'b0, 0);
    cpu_cycle(16'hFFFF, 8'h33, 1'b0, 0);
    cpu_cycle(16'h8005, 8'h44, 1'b1, 0);
    snoop_enable = 1'b0;
    cpu_cycle(16'h8001, 8'h55, 1'b0, 0);
    snoop_enable = 1'b1;
    check("ign_peak", 32'(peak), 0);
    read_chk("ign_sh0", 11'h000, 8'h41);
    read_chk("ign_sh1", 11'h001, 8'hA1);
    read_chk("ign_sh5", 11'h005, 8'hA5);

    // Freeze, overfill by one, then drain.
    freeze = 1'b1;
    for (int i = 0; i < 9; i++) cpu_cycle(16'h8010 + 16'(i), 8'h10 + 8'(i), 1'b0, 0);
    check("frz_level", 32'(fifo_level), 8);
    check("frz_overflow", 32'(overflow), 1);
    check("frz_drop_count", 32'(drop_count), 1);
    freeze = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge fpga_clk);
      check("drain_level", 32'(fifo_level), 32'(i));
    end
    for (int i = 0; i < 8; i++) read_chk("drain_sh", 11'h010 + 11'(i), 8'h10 + 8'(i));
    read_chk("drain_sh18", 11'h018, 8'h5A);

    clear_overflow = 1'b1;
    @(negedge fpga_clk);
    clear_overflow = 1'b0;
    check("clr_overflow", 32'(overflow), 0);
    check("clr_drop_count", 32'(drop_count), 0);

    // Ninth push coincides with the first pop.
    freeze = 1'b1;
    for (int i = 0; i < 8; i++) cpu_cycle(16'h8020 + 16'(i), 8'h20 + 8'(i), 1'b0, 0);
    check("full_level", 32'(fifo_level), 8);
    cpu_cycle(16'h8028, 8'h28, 1'b0, 1);
    check("full_pop_overflow", 32'(overflow), 0);
    check("full_pop_drop", 32'(drop_count), 0);
    repeat (10) @(negedge fpga_clk);
    check("full_pop_drained", 32'(fifo_level), 0);
    read_chk("full_pop_sh28", 11'h028, 8'h28);

    // Clear coinciding with a fresh drop.
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) cpu_cycle(16'h8030 + 16'(i), 8'h30 + 8'(i), 1'b0, 0);
    check("drop2_count", 32'(drop_count), 2);
    cpu_cycle(16'h803A, 8'h3A, 1'b0, 2);
    check("clr_drop_overflow", 32'(overflow), 1);
    check("clr_drop_count", 32'(drop_count), 1);
    freeze = 1'b0;
    repeat (10) @(negedge fpga_clk);
    clear_overflow = 1'b1;
    @(negedge fpga_clk);
    clear_overflow = 1'b0;

    // Reset with five writes queued.
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) cpu_cycle(16'h8010 + 16'(i), 8'hE0 + 8'(i), 1'b0, 0);
    check("rq_level", 32'(fifo_level), 5);
    #2 fpga_reset = 1'b0;
    #1 check("rq_level_async", 32'(fifo_level), 0);
    @(negedge fpga_clk);
    fpga_reset = 1'b1;
    freeze = 1'b0;
    repeat (3) @(negedge fpga_clk);
    check("rq_level_after", 32'(fifo_level), 0);
    for (int i = 0; i < 5; i++) read_chk("rq_sh", 11'h010 + 11'(i), 8'h10 + 8'(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_snoop.md
Name: vram_snoop

Overview:
- Passive CPU-bus snooper that mirrors CPU writes into the video-RAM window into an on-FPGA 2 KB shadow buffer.
- Its read port feeds the diagnostics block's vram_address / vram_data interface, used for SPI screen readout.
- Snooped writes pass through a small FIFO so RAM updates can be frozen while a readout is in progress; the CPU is never stalled.

Parameters:
VRAM_BASE, 16'h8000, first CPU address of the video window.
VRAM_SIZE, 2048, window size in bytes; VRAM_BASE+VRAM_SIZE <= 16'h10000.
FIFO_DEPTH, 8, snoop write FIFO entries; power of 2, at least 2.

Ports:
fpga_clk  in  1  system clock; all logic on rising edge.
fpga_reset  in  1  asynchronous reset, active low.
cpu_phi2  in  1  CPU phase-2 clock, asynchronous to fpga_clk.
cpu_rwb  in  1  CPU read/write; 0 = write.
cpu_address  in  16  CPU address bus.
cpu_data  in  8  CPU data bus.
snoop_enable  in  1  1 = capture writes.
freeze  in  1  1 = hold shadow RAM contents; writes queue in the FIFO.
vram_address  in  11  read address from diagnostics.
vram_data  out  8  registered read data.
fifo_level  out  4  current FIFO occupancy, 0..FIFO_DEPTH.
overflow  out  1  sticky: a snooped write was dropped.
drop_count  out  8  dropped writes, saturates at 255.
clear_overflow  in  1  1-cycle pulse; clears overflow and drop_count.

Behaviour:
- Reset (async, active low):
  - vram_data=0, fifo_level=0, overflow=0, drop_count=0.
  - FIFO pointers and sync flops cleared; queued entries are discarded.
  - Shadow RAM contents are not reset.
- Synchronisation:
  - cpu_phi2, cpu_rwb, cpu_address and cpu_data each pass through an identical 2-flop pipeline.
  - A bus event occurs in the cycle the synchronised phi2 is 1 in stage 2 and 0 in stage 1 (falling edge).
  - On an event, rwb, address and data are taken from stage 2, so they are aligned with phi2 at its high phase.
  - fpga_clk must be at least 8x the phi2 frequency.
- Capture: on an event with snoop_enable=1, rwb=0, and off = cpu_address - VRAM_BASE (16-bit unsigned) < VRAM_SIZE, push {off[10:0], data}.
- Ignored: read cycles, out-of-window addresses (for example VRAM_BASE-1 and VRAM_BASE+VRAM_SIZE), and snoop_enable=0.
- FIFO: synchronous, first-in first-out; fifo_level is updated in the cycle after a push or pop.
- Drain:
  - When freeze=0 and the FIFO is non-empty, pop one entry per cycle and write it to shadow RAM that same cycle.
  - When freeze=1 there are no pops.
- Full and simultaneous events:
  - Push while full with no pop: entry dropped, overflow<=1, drop_count+1 (saturating).
  - Push while full with a pop in the same cycle: accepted, no drop.
  - Push and pop while non-empty: fifo_level unchanged.
- clear_overflow: clears overflow and drop_count next cycle. If a drop occurs in the same cycle, overflow=1 and drop_count=1.
- Read port:
  - vram_data <= shadow[vram_address] every cycle; latency is 1 cycle.
  - A write and a read to the same address in the same cycle returns the old data (read-before-write). The new value is visible one cycle later.
- Shadow RAM: simple dual port, 2048x8, sized for EBR inference. Writes only come from the drain.
- Worst-case latency, event to RAM write, FIFO empty and freeze=0:
  - 2 sync cycles, then push on the event cycle;
  - RAM write in the cycle after the push;
  - vram_data shows the new value one cycle after that.

Test Plan:
- Write 0x41 to 0x8000, freeze=0, vram_address=0 → fifo_level peaks at 1, returns to 0; vram_data=0x41 within 5 fpga_clk cycles of the synced phi2 fall.
- Writes to 0x7FFF, 0x8800 and 0xFFFF, a read at 0x8005 with rwb=1, and a write to 0x8001 with snoop_enable=0 → fifo_level stays 0; shadow[0], shadow[1] and shadow[5] are unchanged.
- freeze=1, nine writes 0x8010..0x8018 with data 0x10..0x18 → fifo_level=8, overflow=1, drop_count=1. Then freeze=0 → 8 consecutive RAM writes; shadow[0x10..0x17]=0x10..0x17, shadow[0x18] unchanged.
- Full FIFO with freeze released in the same cycle as a 9th push → no drop, overflow stays 0.
- clear_overflow pulse after the drop test → overflow=0, drop_count=0. A pulse coincident with a new drop → overflow=1, drop_count=1.
- Assert fpga_reset with 5 entries queued → fifo_level=0 immediately; after reset those 5 addresses hold their pre-freeze values.
